// File: rtl/dot_product_pipe_if.sv
// Stream and coefficient-programming bundle for dot_product_pipe.
// The DUT connects through the slave modport, its driver through the master modport.
interface dot_product_pipe_if #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned LENGTH      = 3,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned ADDR_WIDTH  = $clog2(LENGTH * NUM_OUT)
);
  logic                          coeff_we;
  logic [ADDR_WIDTH-1:0]         coeff_addr;
  logic [COEFF_WIDTH-1:0]        coeff_wdata;
  logic                          coeff_commit;
  logic                          commit_pending;
  logic                          datai_valid;
  logic                          datai_ready;
  logic                          datai_sof;
  logic [LENGTH*DATA_WIDTH-1:0]  datai;
  logic                          datao_valid;
  logic                          datao_ready;
  logic                          datao_sof;
  logic [NUM_OUT*DATA_WIDTH-1:0] datao;
  logic [15:0]                   sat_count;

  modport master (
    output coeff_we, coeff_addr, coeff_wdata, coeff_commit,
    output datai_valid, datai_sof, datai, datao_ready,
    input  commit_pending, datai_ready, datao_valid, datao_sof, datao, sat_count
  );

  modport slave (
    input  coeff_we, coeff_addr, coeff_wdata, coeff_commit,
    input  datai_valid, datai_sof, datai, datao_ready,
    output commit_pending, datai_ready, datao_valid, datao_sof, datao, sat_count
  );
endinterface

// File: rtl/dot_product_pipe.sv
// Streaming NUM_OUT x LENGTH fixed-point dot product: products, sums, then rounded/saturated
// output, all held by one stall enable. Coefficients swap from a shadow bank at frame start.
module dot_product_pipe #(
  parameter int unsigned DATA_WIDTH       = 10,
  parameter int unsigned COEFF_WIDTH      = 8,
  parameter int unsigned COEFF_FRAC_WIDTH = 5,
  parameter int unsigned LENGTH           = 3,
  parameter int unsigned NUM_OUT          = 3,
  parameter bit          SIGNED_COEFF     = 1'b1,
  parameter bit          SIGNED_DATA      = 1'b0
) (
  input logic               clk,
  input logic               reset,
  dot_product_pipe_if.slave bus
);
  localparam int unsigned NumCoeff = LENGTH * NUM_OUT;
  localparam int unsigned OpWidth  = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int unsigned SumWidth = OpWidth + $clog2(LENGTH);

  typedef logic signed [OpWidth-1:0]  op_t;
  typedef logic signed [SumWidth-1:0] sum_t;
  typedef logic [COEFF_WIDTH-1:0]     coeff_t;

  localparam longint SatMaxL = SIGNED_DATA ? (longint'(1) << (DATA_WIDTH - 1)) - 1
                                           : (longint'(1) << DATA_WIDTH) - 1;
  localparam longint SatMinL = SIGNED_DATA ? -(longint'(1) << (DATA_WIDTH - 1)) : longint'(0);
  localparam sum_t   SatMax    = sum_t'(SatMaxL);
  localparam sum_t   SatMin    = sum_t'(SatMinL);
  localparam sum_t   RoundBias = sum_t'(longint'(1) << (COEFF_FRAC_WIDTH - 1));

  function automatic coeff_t identity_coeff(int unsigned idx);
    return (idx % LENGTH == idx / LENGTH) ? coeff_t'(1 << COEFF_FRAC_WIDTH) : '0;
  endfunction

  function automatic op_t ext_data(logic [DATA_WIDTH-1:0] d);
    return SIGNED_DATA ? op_t'($signed(d)) : op_t'($unsigned(d));
  endfunction

  function automatic op_t ext_coeff(coeff_t c);
    return SIGNED_COEFF ? op_t'($signed(c)) : op_t'($unsigned(c));
  endfunction

  coeff_t                        active_q [NumCoeff];
  coeff_t                        shadow_q [NumCoeff];
  logic                          commit_pending_q;
  op_t                           prod_d   [NumCoeff];
  op_t                           prod_q   [NumCoeff];
  logic                          s1_valid_q, s1_sof_q;
  sum_t                          sum_d    [NUM_OUT];
  sum_t                          sum_q    [NUM_OUT];
  logic                          s2_valid_q, s2_sof_q;
  logic [NUM_OUT*DATA_WIDTH-1:0] datao_d, datao_q;
  logic                          datao_valid_q, datao_sof_q;
  logic [15:0]                   sat_count_d, sat_count_q;

  logic en, accept, swap;

  assign en              = !datao_valid_q || bus.datao_ready;
  assign bus.datai_ready = en && !reset;
  assign accept          = bus.datai_valid && bus.datai_ready;
  // The swapping beat must already multiply by the shadow values.
  assign swap            = accept && bus.datai_sof && (commit_pending_q || bus.coeff_commit);

  always_comb begin
    for (int unsigned i = 0; i < NumCoeff; i++) begin
      prod_d[i] = ext_data(bus.datai[(LENGTH - 1 - i % LENGTH) * DATA_WIDTH +: DATA_WIDTH])
                * ext_coeff(swap ? shadow_q[i] : active_q[i]);
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      sum_d[o] = '0;
      for (int unsigned t = 0; t < LENGTH; t++) begin
        sum_d[o] = sum_d[o] + sum_t'(prod_q[o * LENGTH + t]);
      end
    end
  end

  always_comb begin
    sum_t        rnd;
    int unsigned n_sat;
    logic [16:0] sat_sum;
    datao_d     = '0;
    n_sat       = 0;
    rnd         = '0;
    sat_sum     = '0;
    sat_count_d = sat_count_q;
    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      rnd = (sum_q[o] + RoundBias) >>> COEFF_FRAC_WIDTH;
      if (rnd > SatMax) begin
        datao_d[(NUM_OUT - 1 - o) * DATA_WIDTH +: DATA_WIDTH] = SatMax[DATA_WIDTH-1:0];
        n_sat++;
      end else if (rnd < SatMin) begin
        datao_d[(NUM_OUT - 1 - o) * DATA_WIDTH +: DATA_WIDTH] = SatMin[DATA_WIDTH-1:0];
        n_sat++;
      end else begin
        datao_d[(NUM_OUT - 1 - o) * DATA_WIDTH +: DATA_WIDTH] = rnd[DATA_WIDTH-1:0];
      end
    end
    if (s2_valid_q) begin
      sat_sum     = {1'b0, sat_count_q} + 17'(n_sat);
      sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumCoeff; i++) begin
        active_q[i] <= identity_coeff(i);
        shadow_q[i] <= identity_coeff(i);
        prod_q[i]   <= '0;
      end
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
        sum_q[o] <= '0;
      end
      commit_pending_q <= 1'b0;
      s1_valid_q       <= 1'b0;
      s1_sof_q         <= 1'b0;
      s2_valid_q       <= 1'b0;
      s2_sof_q         <= 1'b0;
      datao_q          <= '0;
      datao_valid_q    <= 1'b0;
      datao_sof_q      <= 1'b0;
      sat_count_q      <= '0;
    end else begin
      // Copy reads the old shadow, so a same-cycle write stays in shadow only.
      for (int unsigned i = 0; i < NumCoeff; i++) begin
        if (swap) active_q[i] <= shadow_q[i];
        if (bus.coeff_we && 32'(bus.coeff_addr) == i) shadow_q[i] <= bus.coeff_wdata;
      end
      if (swap) begin
        commit_pending_q <= 1'b0;
      end else if (bus.coeff_commit) begin
        commit_pending_q <= 1'b1;
      end
      if (en) begin
        s1_valid_q    <= accept;
        s1_sof_q      <= accept && bus.datai_sof;
        prod_q        <= prod_d;
        s2_valid_q    <= s1_valid_q;
        s2_sof_q      <= s1_sof_q;
        sum_q         <= sum_d;
        datao_valid_q <= s2_valid_q;
        datao_sof_q   <= s2_sof_q;
        datao_q       <= datao_d;
        sat_count_q   <= sat_count_d;
      end
    end
  end

  assign bus.commit_pending = commit_pending_q;
  assign bus.datao_valid    = datao_valid_q;
  assign bus.datao_sof      = datao_sof_q;
  assign bus.datao          = datao_q;
  assign bus.sat_count      = sat_count_q;
endmodule

// File: tb/tb_dot_product_pipe.sv
// Randomised scoreboard bench for dot_product_pipe against an integer-arithmetic model.
module tb_dot_product_pipe;
  logic clk = 1'b0;
  logic reset;

  dot_product_pipe_if #(.DATA_WIDTH(10), .COEFF_WIDTH(8), .LENGTH(3), .NUM_OUT(3)) bus ();

  dot_product_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        sof;
    logic [29:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          m_active[9];
  int          m_shadow[9];
  bit          m_pending;
  int          m_sat;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_ready = 0;
  logic [29:0] last_out = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int as_signed8(int c);
    return (c >= 128) ? c - 256 : c;
  endfunction

  // floor((acc + 16) / 32) for either sign
  function automatic int round_shift(int acc);
    int r = acc + 16;
    return (r >= 0) ? r / 32 : -((-r + 31) / 32);
  endfunction

  function automatic int ch(int k);
    return int'(last_out[(2 - k) * 10 +: 10]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_active[i] = (i % 3 == i / 3) ? 32 : 0;
      m_shadow[i] = m_active[i];
    end
    m_pending = 0;
    m_sat     = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(int d0, int d1, int d2, bit sof);
    int   d[3];
    int   acc, r, nsat;
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2;
    if (sof && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    e.sof  = sof;
    e.data = '0;
    nsat   = 0;
    for (int o = 0; o < 3; o++) begin
      acc = 0;
      for (int t = 0; t < 3; t++) acc += d[t] * as_signed8(m_active[o * 3 + t]);
      r = round_shift(acc);
      if (r > 1023) begin
        r = 1023; nsat++;
      end else if (r < 0) begin
        r = 0; nsat++;
      end
      e.data[(2 - o) * 10 +: 10] = r[9:0];
    end
    exp_q.push_back(e);
    m_sat = (m_sat + nsat > 65535) ? 65535 : m_sat + nsat;
  endtask

  task automatic write_coeff(int addr, int val);
    bus.coeff_we    = 1'b1;
    bus.coeff_addr  = 4'(addr);
    bus.coeff_wdata = 8'(val);
    @(posedge clk);
    if (addr < 9) m_shadow[addr] = val;
    #1;
    bus.coeff_we = 1'b0;
  endtask

  task automatic commit_c();
    bus.coeff_commit = 1'b1;
    @(posedge clk);
    m_pending = 1;
    #1;
    bus.coeff_commit = 1'b0;
  endtask

  task automatic send_beat(int d0, int d1, int d2, bit sof);
    bit rdy;
    bit done = 0;
    bus.datai_valid = 1'b1;
    bus.datai_sof   = sof;
    bus.datai       = {10'(d0), 10'(d1), 10'(d2)};
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      rdy = bus.datai_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(d0, d1, d2, sof);
        done = 1;
      end
      #1;
    end
    if (!done) check("accept_timeout", 64'(done), 64'(1));
    bus.datai_valid = 1'b0;
    bus.datai_sof   = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: a handshake seen at the negedge completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.datao_valid && bus.datao_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(bus.datao_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(bus.datao), 64'(e.data));
          check("out_sof", 64'(bus.datao_sof), 64'(e.sof));
          last_out = bus.datao;
        end
      end
    end
  end

  initial begin
    bus.datao_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.datao_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    reset            = 1'b1;
    bus.coeff_we     = 1'b0;
    bus.coeff_addr   = '0;
    bus.coeff_wdata  = '0;
    bus.coeff_commit = 1'b0;
    bus.datai_valid  = 1'b0;
    bus.datai_sof    = 1'b0;
    bus.datai        = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.datao_valid), 64'(0));
    check("rst_datao", 64'(bus.datao), 64'(0));
    check("rst_sof", 64'(bus.datao_sof), 64'(0));
    check("rst_pending", 64'(bus.commit_pending), 64'(0));
    check("rst_sat", 64'(bus.sat_count), 64'(0));
    check("rst_ready", 64'(bus.datai_ready), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(bus.datao_valid), 64'(0));

    send_beat(100, 40, 8, 1);
    drain();
    check("ident_ch0", 64'(ch(0)), 64'(100));
    check("ident_ch1", 64'(ch(1)), 64'(40));
    check("ident_ch2", 64'(ch(2)), 64'(8));
    check("ident_sat", 64'(bus.sat_count), 64'(0));

    write_coeff(0, 32); write_coeff(1, 240); write_coeff(2, 8);
    commit_c();
    check("pending_set", 64'(bus.commit_pending), 64'(1));
    send_beat(100, 40, 8, 1);
    drain();
    check("signed_ch0", 64'(ch(0)), 64'(82));
    check("pending_clr", 64'(bus.commit_pending), 64'(0));

    write_coeff(0, 1); write_coeff(1, 0); write_coeff(2, 0);
    commit_c();
    send_beat(16, 0, 0, 1);
    drain();
    check("round_up", 64'(ch(0)), 64'(1));
    send_beat(15, 0, 0, 0);
    drain();
    check("round_down", 64'(ch(0)), 64'(0));

    write_coeff(0, 64);
    commit_c();
    send_beat(100, 0, 0, 0);
    drain();
    check("gate_old", 64'(ch(0)), 64'(3));
    check("gate_pending", 64'(bus.commit_pending), 64'(1));
    send_beat(100, 0, 0, 1);
    drain();
    check("gate_new", 64'(ch(0)), 64'(200));
    check("gate_pending_clr", 64'(bus.commit_pending), 64'(0));

    for (int i = 0; i < 9; i++) write_coeff(i, 127);
    commit_c();
    send_beat(1023, 1023, 1023, 1);
    drain();
    check("satp_ch0", 64'(ch(0)), 64'(1023));
    check("satp_ch1", 64'(ch(1)), 64'(1023));
    check("satp_ch2", 64'(ch(2)), 64'(1023));
    check("satp_count", 64'(bus.sat_count), 64'(3));

    for (int i = 0; i < 9; i++) write_coeff(i, (i % 4 == 0) ? 32 : 0);
    write_coeff(0, 128);
    write_coeff(11, 99);
    commit_c();
    send_beat(500, 7, 9, 1);
    drain();
    check("satn_ch0", 64'(ch(0)), 64'(0));
    check("satn_ch1", 64'(ch(1)), 64'(7));
    check("satn_ch2", 64'(ch(2)), 64'(9));
    check("satn_count", 64'(bus.sat_count), 64'(4));

    rand_ready = 1;
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 7) == 0) write_coeff($urandom_range(0, 15), $urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) commit_c();
      send_beat($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                1'($urandom_range(0, 9) == 0));
    end
    drain();
    rand_ready = 0;
    @(posedge clk);
    #1;
    check("rand_sat", 64'(bus.sat_count), 64'(m_sat));

    commit_c();
    send_beat(1, 2, 3, 0);
    send_beat(4, 5, 6, 0);
    send_beat(7, 8, 9, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("flush_valid", 64'(bus.datao_valid), 64'(0));
    check("flush_datao", 64'(bus.datao), 64'(0));
    check("flush_pending", 64'(bus.commit_pending), 64'(0));
    check("flush_sat", 64'(bus.sat_count), 64'(0));
    check("flush_ready", 64'(bus.datai_ready), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_beat(100, 40, 8, 0);
    drain();
    check("flush_id_ch0", 64'(ch(0)), 64'(100));
    check("flush_id_ch1", 64'(ch(1)), 64'(40));
    check("flush_id_ch2", 64'(ch(2)), 64'(8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
